wb_sel_pipe: RTL and testbench
==============================

Name: wb_sel_pipe

Overview:
Parametrised, pipelined writeback selector for the RISC-V core, replacing the single-cycle writeback mux. Registers execute-stage writeback controls one cycle so they line up with synchronous-read memory outputs. Selects among NREG memory regions by address, performs byte/half extraction and sign/zero extension, flags misaligned loads, and holds load data stable across stalls.

Parameters:
DWIDTH, 32, datapath width; fixed at 32 for RV32, a multiple of 8.
NREG, 3, number of memory read channels on mem_rdata.
REGION_IDS, {4'h8,4'h4,4'h1}, packed NREG×4 region ids compared against addr[31:28]; channel i uses bits [4i+3:4i].
REGION_MASKS, {4'hF,4'hF,4'hD}, packed NREG×4 masks; channel i hits when (addr[31:28] & mask_i) == (id_i & mask_i).

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
x_valid  in  1  execute-stage instruction valid
x_wb_sel  in  2  00 none, 01 ALU, 10 LOAD, 11 PC+4
x_addr  in  32  load address (ALU result)
x_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
x_alu  in  DWIDTH  ALU result
x_pc4  in  DWIDTH  PC+4
x_rd  in  5  destination register
x_regwen  in  1  register write enable
stall  in  1  hold writeback stage
mem_rdata  in  NREG×DWIDTH  flattened sync-read outputs; channel i at [DWIDTH·i +: DWIDTH]
wb_data  out  DWIDTH  writeback data
wb_rd  out  5  registered rd
wb_regwen  out  1  registered write enable, qualified
wb_valid  out  1  writeback-stage valid
misaligned  out  1  misaligned load in writeback stage

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset: all stage registers 0, including wb_valid, wb_regwen, wb_rd, the sel register (00, so wb_data=0), the held flag and the hold register. misaligned=0. Deasserting rst_n mid-stall clears held.
- Latency: inputs sampled at edge t, outputs valid in cycle t+1. mem_rdata is consumed combinationally in cycle t+1.
- Bubble: x_valid=0 loads wb_valid=0 and wb_regwen=0. wb_data is then 0.
- Select, from the registered sel:
  - 01: wb_data = alu_q.
  - 11: wb_data = pc4_q.
  - 00: wb_data = 0.
  - 10: wb_data = extracted load.
- Region match: lowest-index matching channel wins. No match gives load data 0 with wb_regwen unchanged.
- Extraction uses registered addr[1:0]:
  - LB/LBU: byte at addr[1:0]·8, sign- or zero-extended.
  - LH/LHU: half at addr[1]·16, extended.
  - LW: whole word.
  - Unlisted funct3 values are treated as LW.
- Misaligned: LH/LHU with addr[0]=1, or LW with addr[1:0]≠0.
  - misaligned=1, wb_regwen forced 0, wb_data=0.
  - Evaluated only when sel=10 and wb_valid=1.
- Stall: stage registers hold while stall=1.
  - First stall cycle with a load in the stage: capture the extracted data into hold_q and set held=1.
  - While held=1, wb_data = hold_q, regardless of mem_rdata.
  - held clears on the first edge with stall=0, as the stage advances.
  - Non-load sel values never set held.
- Simultaneous stall and reset: reset wins.

Optional Feature:
WB_FWD_EN. When defined, adds:
- inputs x_rs1[4:0] and x_rs2[4:0];
- outputs fwd1_hit and fwd2_hit, each = wb_valid & wb_regwen & (wb_rd≠0) & (wb_rd==x_rsN), combinational.

ALU operand muxes use these hits to select wb_data. When not defined, those ports and that logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package riscv_pkg holds:
  - WB_NONE / WB_ALU / WB_LOAD / WB_PC4 encodings;
  - funct3 load constants F3_LB..F3_LHU;
  - REGION_BITS=4.
- One sub-module, load_extract: combinational data/funct3/addr[1:0] → extended word plus misaligned flag.

Test Plan:
- LB, addr 0x1000_0003, channel0 word 0x8012_3456 → wb_data 0xFFFF_FF80 next cycle. LBU on the same address → 0x0000_0080.
- LH, addr 0x1000_0001 → misaligned=1, wb_regwen=0, wb_data=0. LHU at 0x1000_0002 on word 0x8012_3456 → 0x0000_8012.
- LW, addr 0x4000_0000, channel1=0xDEAD_BEEF, channel0=0x1111_1111 → 0xDEAD_BEEF. LW at addr 0x2000_0000 (no match) → 0, wb_regwen=1.
- Load 0x1234_5678 then stall=1 for 3 cycles while mem_rdata changes each cycle → wb_data stays 0x1234_5678. After stall drops, the next instruction appears.
- rst_n low during held stall → next cycle wb_valid=0, wb_data=0, held=0. After release, x_wb_sel=11 with pc4 0x0000_0104 → 0x0000_0104.
- WB_FWD_EN: wb_rd=5, regwen=1, x_rs2=5 → fwd2_hit=1. Same with wb_rd=0 → both hits 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V encodings: writeback select values, load funct3 codes and region id width.
package riscv_pkg;

  localparam int unsigned REGION_BITS = 4;

  typedef enum logic [1:0] {
    WB_NONE = 2'b00,
    WB_ALU  = 2'b01,
    WB_LOAD = 2'b10,
    WB_PC4  = 2'b11
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extract.sv
// Combinational load lane extraction with sign/zero extension and alignment check.
module load_extract
  import riscv_pkg::*;
#(
  parameter int unsigned DWIDTH = 32
) (
  input  logic [DWIDTH-1:0] data_i,
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        addr_lo_i,
  output logic [DWIDTH-1:0] data_o,
  output logic              misaligned_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v       = data_i[{addr_lo_i, 3'b000} +: 8];
    half_v       = data_i[{addr_lo_i[1], 4'b0000} +: 16];
    data_o       = data_i;
    misaligned_o = 1'b0;
    case (funct3_i)
      F3_LB:  data_o = {{(DWIDTH - 8){byte_v[7]}}, byte_v};
      F3_LBU: data_o = {{(DWIDTH - 8){1'b0}}, byte_v};
      F3_LH: begin
        data_o       = {{(DWIDTH - 16){half_v[15]}}, half_v};
        misaligned_o = addr_lo_i[0];
      end
      F3_LHU: begin
        data_o       = {{(DWIDTH - 16){1'b0}}, half_v};
        misaligned_o = addr_lo_i[0];
      end
      // LW and every unlisted code take the whole word
      default: begin
        data_o       = data_i;
        misaligned_o = |addr_lo_i;
      end
    endcase
  end

endmodule

// File: rtl/wb_sel_pipe.sv
// Pipelined writeback selector: registers execute-stage controls one cycle to meet sync-read
// memory data. Optional operand forwarding hit outputs are built when WB_FWD_EN is defined.
module wb_sel_pipe
  import riscv_pkg::*;
#(
  parameter int unsigned                   DWIDTH       = 32,
  parameter int unsigned                   NREG         = 3,
  parameter logic [NREG*REGION_BITS-1:0]   REGION_IDS   = {4'h8, 4'h4, 4'h1},
  parameter logic [NREG*REGION_BITS-1:0]   REGION_MASKS = {4'hF, 4'hF, 4'hD}
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   x_valid,
  input  logic [1:0]             x_wb_sel,
  input  logic [31:0]            x_addr,
  input  logic [2:0]             x_funct3,
  input  logic [DWIDTH-1:0]      x_alu,
  input  logic [DWIDTH-1:0]      x_pc4,
  input  logic [4:0]             x_rd,
  input  logic                   x_regwen,
  input  logic                   stall,
`ifdef WB_FWD_EN
  input  logic [4:0]             x_rs1,
  input  logic [4:0]             x_rs2,
  output logic                   fwd1_hit,
  output logic                   fwd2_hit,
`endif
  input  logic [NREG*DWIDTH-1:0] mem_rdata,
  output logic [DWIDTH-1:0]      wb_data,
  output logic [4:0]             wb_rd,
  output logic                   wb_regwen,
  output logic                   wb_valid,
  output logic                   misaligned
);

  typedef struct packed {
    logic                   valid;
    wb_sel_e                sel;
    logic                   regwen;
    logic [4:0]             rd;
    logic [2:0]             funct3;
    logic [REGION_BITS-1:0] rgn;
    logic [1:0]             alo;
    logic [DWIDTH-1:0]      alu;
    logic [DWIDTH-1:0]      pc4;
  } stage_t;

  stage_t            stage_q, stage_d;
  logic              held_q, held_d;
  logic [DWIDTH-1:0] hold_q, hold_d;

  logic              hit;
  logic [DWIDTH-1:0] mem_word;
  logic [DWIDTH-1:0] ext_data;
  logic              ext_mis;
  logic [DWIDTH-1:0] load_data;
  logic              is_load;

  // Only the region nibble and byte offset of the address matter here
  logic unused_addr;
  assign unused_addr = ^x_addr[31-REGION_BITS:2];

  // Lowest-index matching channel wins
  always_comb begin
    hit      = 1'b0;
    mem_word = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (!hit && ((stage_q.rgn & REGION_MASKS[i*REGION_BITS +: REGION_BITS]) ==
                   (REGION_IDS[i*REGION_BITS +: REGION_BITS] &
                    REGION_MASKS[i*REGION_BITS +: REGION_BITS]))) begin
        hit      = 1'b1;
        mem_word = mem_rdata[i*DWIDTH +: DWIDTH];
      end
    end
  end

  load_extract #(
    .DWIDTH(DWIDTH)
  ) u_load_extract (
    .data_i      (mem_word),
    .funct3_i    (stage_q.funct3),
    .addr_lo_i   (stage_q.alo),
    .data_o      (ext_data),
    .misaligned_o(ext_mis)
  );

  assign load_data = ext_mis ? '0 : ext_data;
  assign is_load   = stage_q.valid && (stage_q.sel == WB_LOAD);

  always_comb begin
    stage_d = stage_q;
    held_d  = held_q;
    hold_d  = hold_q;
    if (stall) begin
      // Memory output may move on during a stall, so freeze the load result once
      if (!held_q && is_load) begin
        held_d = 1'b1;
        hold_d = load_data;
      end
    end else begin
      stage_d.valid  = x_valid;
      stage_d.sel    = x_valid ? wb_sel_e'(x_wb_sel) : WB_NONE;
      stage_d.regwen = x_valid & x_regwen;
      stage_d.rd     = x_rd;
      stage_d.funct3 = x_funct3;
      stage_d.rgn    = x_addr[31 -: REGION_BITS];
      stage_d.alo    = x_addr[1:0];
      stage_d.alu    = x_alu;
      stage_d.pc4    = x_pc4;
      held_d         = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
      held_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      stage_q <= stage_d;
      held_q  <= held_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    misaligned = is_load & ext_mis;
    wb_regwen  = stage_q.regwen & ~misaligned;
    wb_valid   = stage_q.valid;
    wb_rd      = stage_q.rd;
    wb_data    = '0;
    if (held_q) begin
      wb_data = hold_q;
    end else begin
      unique case (stage_q.sel)
        WB_ALU:  wb_data = stage_q.alu;
        WB_PC4:  wb_data = stage_q.pc4;
        WB_LOAD: wb_data = load_data;
        default: wb_data = '0;
      endcase
    end
  end

`ifdef WB_FWD_EN
  assign fwd1_hit = wb_valid & wb_regwen & (wb_rd != 5'd0) & (wb_rd == x_rs1);
  assign fwd2_hit = wb_valid & wb_regwen & (wb_rd != 5'd0) & (wb_rd == x_rs2);
`endif

endmodule

// File: tb/tb_wb_sel_pipe.sv
// Self-checking bench for wb_sel_pipe: directed cases with literal expectations plus a random run
// against a behavioural writeback model. Forwarding checks compile in with WB_FWD_EN.
module tb_wb_sel_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        x_valid;
  logic [1:0]  x_wb_sel;
  logic [31:0] x_addr;
  logic [2:0]  x_funct3;
  logic [31:0] x_alu;
  logic [31:0] x_pc4;
  logic [4:0]  x_rd;
  logic        x_regwen;
  logic        stall;
  logic [95:0] mem_rdata;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_regwen;
  logic        wb_valid;
  logic        misaligned;
`ifdef WB_FWD_EN
  logic [4:0]  x_rs1;
  logic [4:0]  x_rs2;
  logic        fwd1_hit;
  logic        fwd2_hit;
`endif

  always #5 clk = ~clk;

  wb_sel_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .x_valid   (x_valid),
    .x_wb_sel  (x_wb_sel),
    .x_addr    (x_addr),
    .x_funct3  (x_funct3),
    .x_alu     (x_alu),
    .x_pc4     (x_pc4),
    .x_rd      (x_rd),
    .x_regwen  (x_regwen),
    .stall     (stall),
`ifdef WB_FWD_EN
    .x_rs1     (x_rs1),
    .x_rs2     (x_rs2),
    .fwd1_hit  (fwd1_hit),
    .fwd2_hit  (fwd2_hit),
`endif
    .mem_rdata (mem_rdata),
    .wb_data   (wb_data),
    .wb_rd     (wb_rd),
    .wb_regwen (wb_regwen),
    .wb_valid  (wb_valid),
    .misaligned(misaligned)
  );

  int checks   = 0;
  int failures = 0;

  // Region table: channel i hits when (nibble & mask) == (id & mask)
  int ids[3]   = '{1, 4, 8};
  int masks[3] = '{13, 15, 15};

  // Writeback-stage contents as seen by the model
  bit          m_valid, m_regwen, m_held;
  logic [1:0]  m_sel;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  logic [31:0] m_addr, m_alu, m_pc4, m_hold;

  function automatic logic [31:0] region_word(logic [31:0] addr, logic [95:0] mem);
    for (int i = 0; i < 3; i++) begin
      if ((int'(addr >> 28) & masks[i]) == (ids[i] & masks[i])) return mem[32*i +: 32];
    end
    return 32'h0;
  endfunction

  function automatic bit is_mis(logic [31:0] addr, logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1'b0;
      3'd1, 3'd5: return (addr % 2) != 0;
      default:    return (addr % 4) != 0;
    endcase
  endfunction

  function automatic logic [31:0] extract(logic [31:0] word, logic [31:0] addr, logic [2:0] f3);
    int      nbytes;
    bit      sgn;
    int      off;
    longint  msk;
    longint  v;
    case (f3)
      3'd0:    begin nbytes = 1; sgn = 1'b1; end
      3'd4:    begin nbytes = 1; sgn = 1'b0; end
      3'd1:    begin nbytes = 2; sgn = 1'b1; end
      3'd5:    begin nbytes = 2; sgn = 1'b0; end
      default: begin nbytes = 4; sgn = 1'b0; end
    endcase
    off = (nbytes == 4) ? 0 : (nbytes == 2) ? int'(addr % 4) / 2 * 2 : int'(addr % 4);
    msk = (64'd1 << (8 * nbytes)) - 1;
    v   = (longint'(word) >> (8 * off)) & msk;
    if (sgn && ((v >> (8 * nbytes - 1)) & 1) == 1) v = v | ~msk;
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_load();
    if (is_mis(m_addr, m_f3)) return 32'h0;
    return extract(region_word(m_addr, mem_rdata), m_addr, m_f3);
  endfunction

  task automatic model_clear();
    m_valid = 0; m_regwen = 0; m_held = 0; m_sel = 0; m_rd = 0; m_f3 = 0;
    m_addr = 0; m_alu = 0; m_pc4 = 0; m_hold = 0;
  endtask

  task automatic model_edge();
    if (stall) begin
      if (!m_held && m_valid && m_sel == 2'b10) begin
        m_hold = model_load();
        m_held = 1;
      end
    end else begin
      m_valid  = x_valid;
      m_sel    = x_valid ? x_wb_sel : 2'b00;
      m_regwen = x_valid && x_regwen;
      m_rd     = x_rd;
      m_f3     = x_funct3;
      m_addr   = x_addr;
      m_alu    = x_alu;
      m_pc4    = x_pc4;
      m_held   = 0;
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    bit          e_mis;
    bit          e_we;
    logic [31:0] e_data;
    e_mis = m_valid && m_sel == 2'b10 && is_mis(m_addr, m_f3);
    e_we  = m_regwen && !e_mis;
    if (m_held) e_data = m_hold;
    else begin
      case (m_sel)
        2'b01:   e_data = m_alu;
        2'b11:   e_data = m_pc4;
        2'b10:   e_data = model_load();
        default: e_data = 32'h0;
      endcase
    end
    chk("wb_valid", {31'd0, wb_valid}, {31'd0, m_valid});
    chk("wb_rd", {27'd0, wb_rd}, {27'd0, m_rd});
    chk("wb_regwen", {31'd0, wb_regwen}, {31'd0, e_we});
    chk("misaligned", {31'd0, misaligned}, {31'd0, e_mis});
    chk("wb_data", wb_data, e_data);
`ifdef WB_FWD_EN
    chk("fwd1_hit", {31'd0, fwd1_hit},
        {31'd0, m_valid && e_we && m_rd != 0 && m_rd == x_rs1});
    chk("fwd2_hit", {31'd0, fwd2_hit},
        {31'd0, m_valid && e_we && m_rd != 0 && m_rd == x_rs2});
`endif
  endtask

  task automatic drv(bit v, logic [1:0] s, logic [31:0] a, logic [2:0] f, logic [31:0] alu,
                     logic [31:0] pc4, logic [4:0] rd, bit we, bit st);
    x_valid = v; x_wb_sel = s; x_addr = a; x_funct3 = f; x_alu = alu; x_pc4 = pc4;
    x_rd = rd; x_regwen = we; stall = st;
  endtask

  // One clock: model follows the edge, then this cycle's memory data appears and is checked
  task automatic cycle(logic [95:0] mem);
    @(posedge clk);
    if (rst_n) model_edge();
    #1 mem_rdata = mem;
    #1 compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    #1 compare_all();
    chk("rst_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_data", wb_data, 32'd0);
    @(posedge clk);
    #2 compare_all();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] r, a;
    logic [3:0]  nibs[8] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9, 4'hC};
    rst_n = 1'b0;
    drv(0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    mem_rdata = '0;
`ifdef WB_FWD_EN
    x_rs1 = 0; x_rs2 = 0;
`endif
    model_clear();
    #1 compare_all();
    chk("reset_regwen", {31'd0, wb_regwen}, 32'd0);
    chk("reset_mis", {31'd0, misaligned}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Byte loads from channel 0
    drv(1, 2'b10, 32'h1000_0003, 3'b000, 0, 0, 5'd3, 1, 0);
    cycle({64'h0, 32'h8012_3456});
    chk("lb_lit", wb_data, 32'hFFFF_FF80);
    drv(1, 2'b10, 32'h1000_0003, 3'b100, 0, 0, 5'd3, 1, 0);
    cycle({64'h0, 32'h8012_3456});
    chk("lbu_lit", wb_data, 32'h0000_0080);
    // Half loads
    drv(1, 2'b10, 32'h1000_0001, 3'b001, 0, 0, 5'd4, 1, 0);
    cycle({64'h0, 32'h8012_3456});
    chk("lh_mis_lit", {31'd0, misaligned}, 32'd1);
    chk("lh_mis_we_lit", {31'd0, wb_regwen}, 32'd0);
    chk("lh_mis_data_lit", wb_data, 32'd0);
    drv(1, 2'b10, 32'h1000_0002, 3'b101, 0, 0, 5'd4, 1, 0);
    cycle({64'h0, 32'h8012_3456});
    chk("lhu_lit", wb_data, 32'h0000_8012);
    // Word loads: region select and no-match
    drv(1, 2'b10, 32'h4000_0000, 3'b010, 0, 0, 5'd6, 1, 0);
    cycle({32'h0, 32'hDEAD_BEEF, 32'h1111_1111});
    chk("lw_ch1_lit", wb_data, 32'hDEAD_BEEF);
    drv(1, 2'b10, 32'h2000_0000, 3'b010, 0, 0, 5'd6, 1, 0);
    cycle({32'h0, 32'hDEAD_BEEF, 32'h1111_1111});
    chk("lw_nomatch_lit", wb_data, 32'h0);
    chk("lw_nomatch_we_lit", {31'd0, wb_regwen}, 32'd1);

    // Stall holds the captured load while memory output keeps changing
    drv(1, 2'b10, 32'h1000_0000, 3'b010, 0, 0, 5'd7, 1, 0);
    cycle({64'h0, 32'h1234_5678});
    drv(1, 2'b01, 0, 0, 32'h0000_A5A5, 0, 5'd8, 1, 1);
    for (int k = 0; k < 3; k++) begin
      r = $urandom;
      cycle({64'h0, r});
      chk("stall_hold_lit", wb_data, 32'h1234_5678);
    end
    stall = 1'b0;
    cycle({64'h0, 32'h0BAD_0BAD});
    chk("after_stall_lit", wb_data, 32'h0000_A5A5);

    // Reset while a held load is in the stage, then a PC+4 writeback
    drv(1, 2'b10, 32'h1000_0000, 3'b010, 0, 0, 5'd9, 1, 0);
    cycle({64'h0, 32'h5555_AAAA});
    stall = 1'b1;
    cycle({64'h0, 32'h0});
    cycle({64'h0, 32'h1});
    chk("held_pre_reset_lit", wb_data, 32'h5555_AAAA);
    do_reset();
    drv(1, 2'b11, 0, 0, 0, 32'h0000_0104, 5'd1, 1, 0);
    cycle(96'h0);
    chk("pc4_lit", wb_data, 32'h0000_0104);

`ifdef WB_FWD_EN
    drv(1, 2'b01, 0, 0, 32'h77, 0, 5'd5, 1, 0);
    cycle(96'h0);
    x_rs1 = 5'd7; x_rs2 = 5'd5;
    #1;
    chk("fwd2_lit", {31'd0, fwd2_hit}, 32'd1);
    chk("fwd1_lit", {31'd0, fwd1_hit}, 32'd0);
    drv(1, 2'b01, 0, 0, 32'h77, 0, 5'd0, 1, 0);
    cycle(96'h0);
    x_rs1 = 5'd0; x_rs2 = 5'd0;
    #1;
    chk("fwd_r0_lit", {30'd0, fwd1_hit, fwd2_hit}, 32'd0);
`endif

    // Randomised run against the model
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      a = $urandom;
      a[31:28] = nibs[$urandom_range(0, 7)];
      r = $urandom;
      drv($urandom_range(0, 99) < 85, r[1:0], a, r[4:2], $urandom, $urandom, r[9:5], r[10],
          $urandom_range(0, 99) < 30);
`ifdef WB_FWD_EN
      x_rs1 = r[15:11];
      x_rs2 = ($urandom_range(0, 1) == 1) ? m_rd : r[20:16];
`endif
      cycle({$urandom, $urandom, $urandom});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
